// File: rtl/spypath_delay_meter.sv
// Launch-and-capture delay meter for one spypath chain: toggles the chain input,
// times the synchronized response over 2^TRIALS_LOG2 trials, reports sum/min/max.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  S_IDLE    | waiting for start; results hold their last values
//  S_SETTLE  | chain quiet period; baseline latched on the last cycle
//  S_LAUNCH  | launch edge is on the chain, counting has begun
//  S_MEASURE | counting until cap_s leaves baseline or TIMEOUT is reached
//  S_RECORD  | fold the trial count into sum/min/max, pick next trial
//  S_DONE    | one-cycle done pulse, back to idle
module spypath_delay_meter #(
    parameter int CNT_W       = 16,
    parameter int TRIALS_LOG2 = 3,
    parameter int SETTLE      = 16,
    parameter int TIMEOUT     = 1023
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         path_launch,
    input  logic                         path_capture,
    output logic [CNT_W+TRIALS_LOG2-1:0] delay_sum,
    output logic [CNT_W-1:0]             delay_min,
    output logic [CNT_W-1:0]             delay_max,
    output logic                         timeout_err
);

    localparam int SUM_W = CNT_W + TRIALS_LOG2;
    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_LAUNCH,
        S_MEASURE,
        S_RECORD,
        S_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic                     sync1_q, cap_s_q;
    logic                     baseline_q, baseline_d;
    logic                     launch_q, launch_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [SET_W-1:0]         settle_q, settle_d;
    logic [TRIALS_LOG2-1:0]   trial_q, trial_d;
    logic [SUM_W-1:0]         sum_q, sum_d;
    logic [CNT_W-1:0]         min_q, min_d;
    logic [CNT_W-1:0]         max_q, max_d;
    logic                     terr_q, terr_d;

    logic settle_last;
    logic at_timeout;
    logic edge_seen;
    logic measure_exit;
    logic trial_last;

    assign settle_last  = (settle_q == SET_W'(SETTLE - 1));
    assign at_timeout   = (cnt_q == CNT_W'(TIMEOUT));
    assign edge_seen    = (cap_s_q != baseline_q);
    assign measure_exit = edge_seen || at_timeout;
    assign trial_last   = &trial_q;

    // The chain output is asynchronous; nothing downstream looks at sync1_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            cap_s_q <= 1'b0;
        end else begin
            sync1_q <= path_capture;
            cap_s_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start) state_d = S_SETTLE;
            S_SETTLE:  if (settle_last) state_d = S_LAUNCH;
            S_LAUNCH:  state_d = S_MEASURE;
            S_MEASURE: if (measure_exit) state_d = S_RECORD;
            S_RECORD:  state_d = trial_last ? S_DONE : S_SETTLE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            S_SETTLE, S_LAUNCH, S_MEASURE, S_RECORD: busy = 1'b1;
            S_DONE:                                  done = 1'b1;
            default: ;
        endcase
    end

    // The launch register flips on the edge that enters LAUNCH and the counter is
    // cleared on that same edge, so the count is measured from the edge that
    // actually drives the chain: a plain loopback reads back the 2-flop latency.
    always_comb begin
        baseline_d = baseline_q;
        launch_d   = launch_q;
        cnt_d      = cnt_q;
        settle_d   = settle_q;
        trial_d    = trial_q;
        sum_d      = sum_q;
        min_d      = min_q;
        max_d      = max_q;
        terr_d     = terr_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sum_d    = '0;
                    min_d    = '1;
                    max_d    = '0;
                    terr_d   = 1'b0;
                    trial_d  = '0;
                    settle_d = '0;
                end
            end
            S_SETTLE: begin
                settle_d = settle_q + 1'b1;
                if (settle_last) begin
                    baseline_d = cap_s_q;
                    launch_d   = ~launch_q;
                    cnt_d      = '0;
                end
            end
            S_LAUNCH: begin
                cnt_d = cnt_q + 1'b1;
            end
            S_MEASURE: begin
                if (!measure_exit) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (at_timeout) begin
                    terr_d = 1'b1;
                end
            end
            S_RECORD: begin
                sum_d = sum_q + {{TRIALS_LOG2{1'b0}}, cnt_q};
                if (cnt_q < min_q) begin
                    min_d = cnt_q;
                end
                if (cnt_q > max_q) begin
                    max_d = cnt_q;
                end
                if (!trial_last) begin
                    trial_d  = trial_q + 1'b1;
                    settle_d = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baseline_q <= 1'b0;
            launch_q   <= 1'b0;
            cnt_q      <= '0;
            settle_q   <= '0;
            trial_q    <= '0;
            sum_q      <= '0;
            min_q      <= '1;
            max_q      <= '0;
            terr_q     <= 1'b0;
        end else begin
            baseline_q <= baseline_d;
            launch_q   <= launch_d;
            cnt_q      <= cnt_d;
            settle_q   <= settle_d;
            trial_q    <= trial_d;
            sum_q      <= sum_d;
            min_q      <= min_d;
            max_q      <= max_d;
            terr_q     <= terr_d;
        end
    end

    assign path_launch = launch_q;
    assign delay_sum   = sum_q;
    assign delay_min   = min_q;
    assign delay_max   = max_q;
    assign timeout_err = terr_q;

endmodule
